// File: rtl/l0_feeder.sv
// Streams num_vec SRAM words into the L0 through a 2-entry staging buffer, then strobes l0_rd num_vec times.
// First l0_wr 3 cycles after start, one vector/cycle; l0_ready low stalls pops only, reads throttle to keep staging <= 2.
module l0_feeder #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11,
  parameter int len_w  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [len_w-1:0]    num_vec,
  output logic                busy,
  output logic                done,
  output logic                sram_rd,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_q,
  input  logic                l0_ready,
  output logic                l0_wr,
  output logic [row*bw-1:0]   l0_in,
  output logic                l0_rd,
  output logic                l0_mode
);

  localparam int dw = row * bw;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t              state;
  logic [addr_w-1:0]   base;
  logic [len_w-1:0]    num;
  logic [len_w-1:0]    issued;
  logic [len_w-1:0]    wr_cnt;
  logic [len_w-1:0]    drain_cnt;
  logic [1:0]          occ;
  logic                pend;
  logic [dw-1:0]       stage0;
  logic [dw-1:0]       stage1;
  logic [2:0]          fill;

  // Occupancy after this cycle's push/pop; a new read is allowed only if it will still fit when it lands.
  assign fill      = {1'b0, occ} + {2'b00, pend} - {2'b00, l0_wr};
  assign l0_wr     = (state == LOAD) && (occ != 2'd0) && l0_ready;
  assign sram_rd   = (state == LOAD) && (issued < num) && (fill < 3'd2);
  assign sram_addr = sram_rd ? base + addr_w'(issued) : '0;
  assign l0_mode   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      num       <= '0;
      issued    <= '0;
      wr_cnt    <= '0;
      drain_cnt <= '0;
      occ       <= '0;
      pend      <= 1'b0;
      stage0    <= '0;
      stage1    <= '0;
      l0_in     <= '0;
      l0_rd     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pend <= sram_rd;
      if (sram_rd) issued <= issued + len_w'(1);

      if (l0_wr) begin
        l0_in  <= stage0;
        wr_cnt <= wr_cnt + len_w'(1);
        if (pend) begin
          if (occ == 2'd2) begin
            stage0 <= stage1;
            stage1 <= sram_q;
          end else begin
            stage0 <= sram_q;
          end
        end else begin
          stage0 <= stage1;
          occ    <= occ - 2'd1;
        end
      end else if (pend) begin
        if (occ == 2'd0) stage0 <= sram_q;
        else             stage1 <= sram_q;
        occ <= occ + 2'd1;
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base      <= base_addr;
            num       <= num_vec;
            issued    <= '0;
            wr_cnt    <= '0;
            drain_cnt <= '0;
            busy      <= 1'b1;
            state     <= (num_vec != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (l0_wr && (wr_cnt == num - len_w'(1))) begin
            state     <= DRAIN;
            l0_rd     <= 1'b1;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + len_w'(1);
          if (drain_cnt == num - len_w'(1)) begin
            l0_rd <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // A zero-length command arrives here with done low: its pulse lands on the way back to IDLE.
          busy  <= 1'b0;
          done  <= ~done;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l0_feeder.sv
// Directed bench for l0_feeder: records outputs per cycle at the falling edge and checks them against hand-derived values.
module tb_l0_feeder;
  localparam int AW = 11;
  localparam int LW = 7;
  localparam int DW = 32;
  localparam int NOSTALL_LO = 1000;
  localparam int NOSTALL_HI = -1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_vec = '0;
  logic          busy, done, sram_rd, l0_wr, l0_rd, l0_mode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_q;
  logic          l0_ready = 1'b1;
  logic [DW-1:0] l0_in;

  l0_feeder #(.row(8), .bw(4), .addr_w(AW), .len_w(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_q(sram_q),
    .l0_ready(l0_ready), .l0_wr(l0_wr), .l0_in(l0_in), .l0_rd(l0_rd), .l0_mode(l0_mode)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) if (sram_rd) sram_q <= mem[sram_addr];

  logic          rec_srd  [0:199];
  logic [AW-1:0] rec_addr [0:199];
  logic          rec_wr   [0:199];
  logic [DW-1:0] rec_in   [0:199];
  logic          rec_rd   [0:199];
  logic          rec_done [0:199];
  logic          rec_busy [0:199];

  int passed = 0, failed = 0, total = 0;
  int cnt_srd, cnt_wr, cnt_rd, cnt_done, cnt_busy, first_done, last_wr;
  int maxocc, stall_rd, bad;
  logic [15:0] m_srd, m_wr, m_rd, m_done, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle k starts at posedge k; inputs change just after it, outputs are captured at the falling edge.
  task automatic run(input logic [AW-1:0] b, input logic [LW-1:0] n, input int ncyc,
                     input int st_lo, input int st_hi, input int s1, input int s2);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      l0_ready  = !(k >= st_lo && k <= st_hi);
      start     = (k == s1) || (k == s2);
      base_addr = (k == s2) ? 11'h123 : b;
      num_vec   = (k == s2) ? 7'd3 : n;
      @(negedge clk);
      rec_srd[k]  = sram_rd;
      rec_addr[k] = sram_addr;
      rec_wr[k]   = l0_wr;
      rec_in[k]   = l0_in;
      rec_rd[k]   = l0_rd;
      rec_done[k] = done;
      rec_busy[k] = busy;
    end
    start    = 1'b0;
    l0_ready = 1'b1;
  endtask

  task automatic tally(input int ncyc);
    cnt_srd = 0; cnt_wr = 0; cnt_rd = 0; cnt_done = 0; cnt_busy = 0;
    first_done = -1; last_wr = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (rec_srd[k]) cnt_srd++;
      if (rec_wr[k]) begin cnt_wr++; last_wr = k; end
      if (rec_rd[k]) cnt_rd++;
      if (rec_busy[k]) cnt_busy++;
      if (rec_done[k]) begin
        cnt_done++;
        if (first_done < 0) first_done = k;
      end
    end
  endtask

  // Word written by the j-th l0_wr must be mem[b+j] (default pattern), visible the cycle after the strobe.
  task automatic check_data(input string tag, input logic [AW-1:0] b, input int ncyc);
    logic [AW-1:0] a;
    int j;
    j = 0; bad = 0;
    for (int k = 0; k < ncyc - 1; k++) begin
      if (rec_wr[k]) begin
        a = b + AW'(j);
        if (rec_in[k+1] !== (32'h5A00_0000 | {21'd0, a})) bad++;
        j++;
      end
    end
    check(tag, bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h5A00_0000 | i;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'h1111_1111 * (i + 1);

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sram_rd", sram_rd, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_l0_wr", l0_wr, 0);
    check("rst_l0_rd", l0_rd, 0);
    check("rst_l0_in", l0_in, 0);
    check("rst_l0_mode", l0_mode, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic load/drain, with an extra start during DRAIN that must be ignored.
    run(11'h010, 7'd4, 16, NOSTALL_LO, NOSTALL_HI, 0, 8);
    for (int k = 0; k < 16; k++) begin
      m_srd[k] = rec_srd[k]; m_wr[k] = rec_wr[k]; m_rd[k] = rec_rd[k];
      m_done[k] = rec_done[k]; m_busy[k] = rec_busy[k];
    end
    check("basic_sram_rd_cycles", m_srd, 16'h001E);
    check("basic_l0_wr_cycles", m_wr, 16'h0078);
    check("basic_l0_rd_cycles", m_rd, 16'h0780);
    check("basic_done_cycles", m_done, 16'h0800);
    check("basic_busy_cycles", m_busy, 16'h0FFE);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_addr%0d", i), rec_addr[1+i], 32'h10 + i);
      check($sformatf("basic_l0_in%0d", i), rec_in[4+i], 32'h1111_1111 * (i + 1));
    end

    // Zero length: busy only in cycle 1, done in cycle 2, no traffic.
    run(11'h040, 7'd0, 6, NOSTALL_LO, NOSTALL_HI, 0, -1);
    tally(6);
    check("zero_busy_cnt", cnt_busy, 1);
    check("zero_busy_c1", rec_busy[1], 1);
    check("zero_done_cycle", first_done, 2);
    check("zero_done_cnt", cnt_done, 1);
    check("zero_traffic", cnt_srd + cnt_wr + cnt_rd, 0);

    // Address wrap.
    run(11'h7FE, 7'd4, 12, NOSTALL_LO, NOSTALL_HI, 0, -1);
    check("wrap_addr0", rec_addr[1], 11'h7FE);
    check("wrap_addr1", rec_addr[2], 11'h7FF);
    check("wrap_addr2", rec_addr[3], 11'h000);
    check("wrap_addr3", rec_addr[4], 11'h001);
    check_data("wrap_data", 11'h7FE, 12);

    // Backpressure: l0_ready low in cycles 4..8.
    run(11'h100, 7'd8, 30, 4, 8, 0, -1);
    tally(30);
    maxocc = 0;
    for (int k = 0; k < 30; k++) begin
      int landed, wrs;
      landed = 0; wrs = 0;
      for (int m = 0; m <= k - 2; m++) if (rec_srd[m]) landed++;
      for (int m = 0; m < k; m++) if (rec_wr[m]) wrs++;
      if (landed - wrs > maxocc) maxocc = landed - wrs;
    end
    stall_rd = 0;
    for (int k = 4; k <= 8; k++) if (rec_srd[k]) stall_rd++;
    check("bp_occ_le2", maxocc <= 2, 1);
    check("bp_stall_reads_le2", stall_rd <= 2, 1);
    check("bp_wr_cnt", cnt_wr, 8);
    check("bp_last_wr_cycle", last_wr, 15);
    check("bp_rd_cnt", cnt_rd, 8);
    check("bp_done_cycle", first_done, 24);
    check_data("bp_data", 11'h100, 30);

    // Reset mid-LOAD with two vectors staged and a pop/read active.
    run(11'h200, 7'd8, 7, 4, 5, 0, -1);
    check("pre_rst_busy", rec_busy[6], 1);
    check("pre_rst_l0_wr", rec_wr[6], 1);
    check("pre_rst_sram_rd", rec_srd[6], 1);
    check("pre_rst_l0_in", rec_in[6], 32'h5A00_0200);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sram_rd", sram_rd, 0);
    check("arst_l0_wr", l0_wr, 0);
    check("arst_l0_in", l0_in, 0);
    check("arst_l0_rd", l0_rd, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run(11'h000, 7'd0, 6, NOSTALL_LO, NOSTALL_HI, -1, -1);
    tally(6);
    check("post_rst_no_done", cnt_done, 0);
    check("post_rst_idle", cnt_busy, 0);

    // Full-depth command after the abort.
    run(11'h300, 7'd64, 140, NOSTALL_LO, NOSTALL_HI, 0, -1);
    tally(140);
    check("full_wr_cnt", cnt_wr, 64);
    check("full_rd_cnt", cnt_rd, 64);
    check("full_done_cnt", cnt_done, 1);
    check("full_done_cycle", first_done, 131);
    check_data("full_data", 11'h300, 140);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
